mips_issuer: RTL and testbench

Instruction issuer that drives the `MIPS` execution block, acting as the initiator for its `in_valid`/`instruction`/`output_reg` responder interface. It buffers a program of (instruction, output-register-select) pairs and, on `start`, issues them one at a time. It waits for each `out_valid` and returns the four captured register values and the fail flag upstream. It sits between the testbench or host loader and `MIPS`, and owns per-run fail counting and hang detection.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_issuer_if.sv | 25 ++
 rtl/issuer_fifo.sv | 61 ++++++
 rtl/mips_issuer.sv | 165 ++++++++++++++++
 tb/tb_mips_issuer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction issuer.
//   - MIPS opcode / funct constants used to build and decode program words
//   - the six register addresses the MIPS block exposes on its output ports
//   - issuer FSM state encoding
//   - issue_entry_t: one program entry {instr[31:0], oreg[19:0]}
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [4:0] REG_R17 = 5'b10001;
   localparam logic [4:0] REG_R18 = 5'b10010;
   localparam logic [4:0] REG_R8  = 5'b01000;
   localparam logic [4:0] REG_R23 = 5'b10111;
   localparam logic [4:0] REG_R31 = 5'b11111;
   localparam logic [4:0] REG_R16 = 5'b10000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } issuer_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [19:0] oreg;
   } issue_entry_t;

endpackage

// File: rtl/mips_issuer_if.sv
// Handshake bus between the issuer (master) and the MIPS execution block (slave).
//   in_valid/instruction/output_reg : issuer -> MIPS, one instruction per in_valid pulse
//   out_valid/out_1..out_4          : MIPS -> issuer, the four selected register values
//   instruction_fail                : MIPS -> issuer, instruction could not be executed
interface mips_issuer_if;
   logic        in_valid;
   logic [31:0] instruction;
   logic [19:0] output_reg;
   logic        out_valid;
   logic [15:0] out_1;
   logic [15:0] out_2;
   logic [15:0] out_3;
   logic [15:0] out_4;
   logic        instruction_fail;

   modport master (
      output in_valid, instruction, output_reg,
      input  out_valid, out_1, out_2, out_3, out_4, instruction_fail
   );

   modport slave (
      input  in_valid, instruction, output_reg,
      output out_valid, out_1, out_2, out_3, out_4, instruction_fail
   );
endinterface

// File: rtl/issuer_fifo.sv
// Synchronous program buffer, DEPTH x issue_entry_t, wrap-around pointers.
//   clk, rst_n : clock, synchronous active-low reset (empties the buffer)
//   push/wdata : write at tail (ignored when full)
//   pop        : advance head (ignored when empty)
//   flush      : discard all entries
//   head       : entry at the read pointer
//   full/empty/count : occupancy, count is $clog2(DEPTH)+1 bits
module issuer_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  issue_entry_t             wdata,
   input  logic                     pop,
   input  logic                     flush,
   output issue_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   issue_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mips_issuer.sv
// Instruction issuer for the MIPS execution block.
// Buffers a program of (instruction, output-register-select) pairs, and on
// start issues them one at a time, waits for each MIPS response and returns
// the captured register values upstream. Counts fails and aborts on a hang.
//   clk, rst_n            : clock, synchronous active-low reset
//   load_valid/instr/oreg : program entry from the loader, accepted with load_ready
//   load_ready            : combinational, high only in IDLE with buffer space
//   start                 : begin a run (IDLE only)
//   mips                  : master side of the MIPS handshake bus
//   res_valid/data/fail/timeout/index : one-cycle result strobe and its payload
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   fail_count            : fails plus timeouts of the last or current run
module mips_issuer
   import mips_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load_valid,
   input  logic [31:0]                  load_instr,
   input  logic [19:0]                  load_oreg,
   output logic                         load_ready,
   input  logic                         start,
   mips_issuer_if.master                mips,
   output logic                         res_valid,
   output logic [63:0]                  res_data,
   output logic                         res_fail,
   output logic                         res_timeout,
   output logic [$clog2(DEPTH)-1:0]     res_index,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   fail_count
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   issuer_state_t       state;
   issue_entry_t        load_entry;
   issue_entry_t        head;
   issue_entry_t        first_entry;
   logic                push;
   logic                pop;
   logic                flush;
   logic                full;
   logic                empty;
   logic [IW:0]         fifo_count;
   logic [IW-1:0]       index;
   logic [TW-1:0]       timer;
   logic                tmo_hit;

   assign load_entry = '{instr: load_instr, oreg: load_oreg};
   assign load_ready = (state == ST_IDLE) && !full;
   assign push       = load_valid && load_ready;
   assign pop        = (state == ST_ISSUE);
   assign tmo_hit    = (state == ST_WAIT) && !mips.out_valid && (timer == TMO_LAST);
   assign flush      = tmo_hit;

   // A load accepted in the same cycle as start is part of the run; when the
   // buffer is still empty it is not yet visible at the head, so bypass it.
   assign first_entry = empty ? load_entry : head;

   issuer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (load_entry),
      .pop   (pop),
      .flush (flush),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= (IW+1)'(DEPTH));

   // in_valid is set on the edge that enters ISSUE so it is high exactly while
   // the FSM sits in ISSUE. The timer counts cycles since in_valid, so the
   // abort decision lands TIMEOUT-1 cycles after the issue cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         mips.in_valid    <= 1'b0;
         mips.instruction <= '0;
         mips.output_reg  <= '0;
         res_valid        <= 1'b0;
         res_data         <= '0;
         res_fail         <= 1'b0;
         res_timeout      <= 1'b0;
         res_index        <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         fail_count       <= '0;
         index            <= '0;
         timer            <= '0;
      end else begin
         res_valid     <= 1'b0;
         done          <= 1'b0;
         mips.in_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  fail_count <= '0;
                  index      <= '0;
                  busy       <= 1'b1;
                  if (!empty || push) begin
                     state            <= ST_ISSUE;
                     mips.in_valid    <= 1'b1;
                     mips.instruction <= first_entry.instr;
                     mips.output_reg  <= first_entry.oreg;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_ISSUE: begin
               timer <= TW'(1);
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mips.out_valid) begin
                  res_valid   <= 1'b1;
                  res_data    <= {mips.out_4, mips.out_3, mips.out_2, mips.out_1};
                  res_fail    <= mips.instruction_fail;
                  res_timeout <= 1'b0;
                  res_index   <= index;
                  index       <= index + IW'(1);
                  if (mips.instruction_fail) fail_count <= fail_count + CW'(1);
                  if (!empty) begin
                     state            <= ST_ISSUE;
                     mips.in_valid    <= 1'b1;
                     mips.instruction <= head.instr;
                     mips.output_reg  <= head.oreg;
                  end else begin
                     state <= ST_DONE;
                  end
               end else if (tmo_hit) begin
                  res_valid   <= 1'b1;
                  res_data    <= '0;
                  res_fail    <= 1'b0;
                  res_timeout <= 1'b1;
                  res_index   <= index;
                  fail_count  <= fail_count + CW'(1);
                  state       <= ST_DONE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_issuer.sv
// Testbench for mips_issuer: a small MIPS responder (ADDI and R-type ADD,
// anything else fails), directed program loads, and a scoreboard of
// hand-computed results checked by an independent monitor.
module tb_mips_issuer;
   import mips_pkg::*;

   localparam int DEPTH = 16;
   localparam int TMO   = 8;

   localparam logic [19:0] ORG16 = 20'h84210;   // r16 in all four slots
   localparam logic [19:0] ORG17 = 20'h8C631;   // r17 in all four slots
   localparam logic [19:0] ORGMX = 20'hFC228;   // {r31, r16, r17, r8}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_instr = '0;
   logic [19:0] load_oreg = '0;
   logic        load_ready;
   logic        start = 1'b0;
   logic        res_valid;
   logic [63:0] res_data;
   logic        res_fail;
   logic        res_timeout;
   logic [3:0]  res_index;
   logic        busy;
   logic        done;
   logic [4:0]  fail_count;

   mips_issuer_if mif();

   mips_issuer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_instr  (load_instr),
      .load_oreg   (load_oreg),
      .load_ready  (load_ready),
      .start       (start),
      .mips        (mif),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_fail    (res_fail),
      .res_timeout (res_timeout),
      .res_index   (res_index),
      .busy        (busy),
      .done        (done),
      .fail_count  (fail_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- MIPS responder ----------------
   typedef struct packed {
      logic        ok;
      logic        we;
      logic [4:0]  wa;
      logic [15:0] wv;
   } exec_t;

   logic        mips_en = 1'b1;
   logic [15:0] rf [32];
   exec_t       ex;

   function automatic exec_t exec(input logic [31:0] ins);
      exec_t r;
      r = '0;
      if (ins[31:26] == OP_ADDI) begin
         r.ok = 1'b1; r.wa = ins[20:16]; r.wv = rf[ins[25:21]] + ins[15:0];
      end else if (ins[31:26] == OP_RTYPE && ins[5:0] == FN_ADD) begin
         r.ok = 1'b1; r.wa = ins[15:11]; r.wv = rf[ins[25:21]] + rf[ins[20:16]];
      end
      r.we = r.ok && (r.wa != 5'd0);
      return r;
   endfunction

   function automatic logic [15:0] rd(input exec_t x, input logic [4:0] a);
      if (!x.ok) return 16'h0;
      if (x.we && a == x.wa) return x.wv;
      return rf[a];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         mif.out_valid        <= 1'b0;
         mif.instruction_fail <= 1'b0;
         mif.out_1 <= '0; mif.out_2 <= '0; mif.out_3 <= '0; mif.out_4 <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         mif.out_valid <= mips_en && mif.in_valid;
         if (mips_en && mif.in_valid) begin
            ex = exec(mif.instruction);
            if (ex.we) rf[ex.wa] <= ex.wv;
            mif.instruction_fail <= !ex.ok;
            mif.out_1 <= rd(ex, mif.output_reg[4:0]);
            mif.out_2 <= rd(ex, mif.output_reg[9:5]);
            mif.out_3 <= rd(ex, mif.output_reg[14:10]);
            mif.out_4 <= rd(ex, mif.output_reg[19:15]);
         end
      end
   end

   // ---------------- checking ----------------
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [63:0] data;
      logic        fail;
      logic        tmo;
      logic [3:0]  idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   iv_q[$];
   int   done_cnt = 0;
   int   done_at = 0;
   int   res_at = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mif.in_valid) iv_q.push_back(cyc);
         if (done) begin done_cnt++; done_at = cyc; end
         if (res_valid) begin
            res_at = cyc;
            check("res_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("res_data",    res_data,    mon_e.data);
               check("res_fail",    res_fail,    mon_e.fail);
               check("res_timeout", res_timeout, mon_e.tmo);
               check("res_index",   res_index,   mon_e.idx);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int s_cyc = 0;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; load_valid = 1'b0; start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic lv, input logic [31:0] ins, input logic [19:0] org, input logic st);
      @(negedge clk);
      load_valid = lv; load_instr = ins; load_oreg = org; start = st;
      @(negedge clk);
      load_valid = 1'b0; start = 1'b0;
      if (st) s_cyc = cyc;
   endtask

   task automatic expect_res(input logic [63:0] d, input logic f, input logic t, input logic [3:0] i);
      exp_t e;
      e.data = d; e.fail = f; e.tmo = t; e.idx = i;
      exp_q.push_back(e);
   endtask

   task automatic clear_obs();
      iv_q.delete();
      done_cnt = 0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("done_seen", 64'(done_cnt), 64'd1);
      check("results_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_in_valid",   mif.in_valid, 1'b0);
      check("rst_busy",       busy, 1'b0);
      check("rst_done",       done, 1'b0);
      check("rst_res_valid",  res_valid, 1'b0);
      check("rst_fail_count", fail_count, 5'd0);
      check("rst_load_ready", load_ready, 1'b1);
      check("rst_instr",      mif.instruction, 32'h0);
      check("rst_res_data",   res_data, 64'h0);

      // Single ADDI r16 = r17 + 5, loaded in the same cycle as start
      clear_obs();
      expect_res(64'h0005_0005_0005_0005, 1'b0, 1'b0, 4'd0);
      drive(1'b1, 32'h2230_0005, ORG16, 1'b1);
      wait_done(20);
      check("t1_iv_count", 64'(iv_q.size()), 64'd1);
      if (iv_q.size() > 0) check("t1_iv_at", 64'(iv_q[0]), 64'(s_cyc));
      check("t1_done_at", 64'(done_at), 64'(s_cyc + 3));
      check("t1_done_after_res", 64'(done_at - res_at), 64'd1);
      check("t1_fail_count", fail_count, 5'd0);

      // Three entries, middle one has an invalid opcode; last load rides with start
      do_reset();
      clear_obs();
      expect_res(64'h0003_0003_0003_0003, 1'b0, 1'b0, 4'd0);
      expect_res(64'h0,                   1'b1, 1'b0, 4'd1);
      expect_res(64'h0000_0000_0003_0006, 1'b0, 1'b0, 4'd2);
      drive(1'b1, 32'h2011_0003, ORG17, 1'b0);
      drive(1'b1, 32'hFC00_0000, ORG16, 1'b0);
      drive(1'b1, 32'h0231_4020, ORGMX, 1'b1);
      wait_done(40);
      check("t2_iv_count", 64'(iv_q.size()), 64'd3);
      if (iv_q.size() == 3) begin
         check("t2_iv0_at",  64'(iv_q[0]), 64'(s_cyc));
         check("t2_iv_gap1", 64'(iv_q[1] - iv_q[0]), 64'd2);
         check("t2_iv_gap2", 64'(iv_q[2] - iv_q[1]), 64'd2);
      end
      check("t2_done_at", 64'(done_at), 64'(s_cyc + 7));
      check("t2_fail_count", fail_count, 5'd1);

      // Fill all DEPTH entries, then offer one more
      do_reset();
      clear_obs();
      for (int i = 0; i < DEPTH; i++) begin
         expect_res({4{16'h0100 + 16'(i)}}, 1'b0, 1'b0, 4'(i));
         drive(1'b1, 32'h2011_0100 + 32'(i), ORG17, 1'b0);
      end
      check("t3_full_ready", load_ready, 1'b0);
      drive(1'b1, 32'h2011_0FFF, ORG17, 1'b0);
      check("t3_extra_ready", load_ready, 1'b0);
      drive(1'b0, 32'h0, 20'h0, 1'b1);
      check("t3_busy", busy, 1'b1);
      check("t3_ready_in_run", load_ready, 1'b0);
      wait_done(100);
      check("t3_iv_count", 64'(iv_q.size()), 64'(DEPTH));
      check("t3_done_at", 64'(done_at), 64'(s_cyc + 2*DEPTH + 1));
      check("t3_fail_count", fail_count, 5'd0);

      // Hang: MIPS never answers, two entries loaded
      do_reset();
      clear_obs();
      mips_en = 1'b0;
      expect_res(64'h0, 1'b0, 1'b1, 4'd0);
      drive(1'b1, 32'h2011_0001, ORG17, 1'b0);
      drive(1'b1, 32'h2011_0002, ORG17, 1'b0);
      drive(1'b0, 32'h0, 20'h0, 1'b1);
      wait_done(40);
      check("t4_iv_count", 64'(iv_q.size()), 64'd1);
      if (iv_q.size() > 0) check("t4_res_latency", 64'(res_at - iv_q[0]), 64'(TMO));
      check("t4_done_at", 64'(done_at), 64'(s_cyc + TMO + 1));
      check("t4_fail_count", fail_count, 5'd1);
      repeat (4) @(negedge clk);
      check("t4_no_reissue", 64'(iv_q.size()), 64'd1);
      mips_en = 1'b1;

      // Start with an empty buffer (the hang flushed the second entry)
      clear_obs();
      drive(1'b0, 32'h0, 20'h0, 1'b1);
      wait_done(10);
      check("t5_done_at", 64'(done_at), 64'(s_cyc + 1));
      check("t5_iv_count", 64'(iv_q.size()), 64'd0);
      check("t5_fail_count", fail_count, 5'd0);

      // Reset while waiting for MIPS
      mips_en = 1'b0;
      drive(1'b1, 32'h2011_0007, ORG17, 1'b0);
      clear_obs();
      drive(1'b0, 32'h0, 20'h0, 1'b1);
      @(negedge clk);
      check("t6_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_busy",       busy, 1'b0);
      check("t6_in_valid",   mif.in_valid, 1'b0);
      check("t6_instr",      mif.instruction, 32'h0);
      check("t6_oreg",       mif.output_reg, 20'h0);
      check("t6_res_valid",  res_valid, 1'b0);
      check("t6_fail_count", fail_count, 5'd0);
      check("t6_load_ready", load_ready, 1'b1);
      mips_en = 1'b1;
      clear_obs();
      repeat (4) @(negedge clk);
      check("t6_no_done", 64'(done_cnt), 64'd0);
      drive(1'b0, 32'h0, 20'h0, 1'b1);
      wait_done(10);
      check("t6_fifo_empty", 64'(iv_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
